// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO slave: window base, register
// offsets, STATUS bit positions and serializer state encoding.
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  // Word offsets (byte offset >> 2) inside the MMIO window
  localparam logic [5:0] OFF_TXDATA = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_GPIO   = 6'h02;
  localparam logic [5:0] OFF_CYCLE  = 6'h03;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// 8N1 serializer: takes one byte per valid/ready handshake in IDLE and shifts
// it out LSB first framed by a start and a stop bit.
module dmem_mmio_uart_tx
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          baud_last;

  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    ready     = 1'b0;
    tx        = 1'b1;
    busy      = 1'b1;
    unique case (state)
      TX_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (valid) begin
          shift_n = data;
          baud_n  = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        tx     = 1'b0;
        baud_n = baud + 1'b1;
        if (baud_last) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = TX_DATA;
        end
      end
      TX_DATA: begin
        tx     = shift[0];
        baud_n = baud + 1'b1;
        if (baud_last) begin
          baud_n    = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        baud_n = baud + 1'b1;
        if (baud_last) begin
          baud_n  = '0;
          state_n = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side slave of the single-cycle core: word RAM plus MMIO window with a
// TX FIFO feeding the serializer, a GPIO register and a free-running cycle counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  output logic        tx,
  output logic        tx_busy,
  output logic [31:0] gpio_out
);

  localparam int RAW = $clog2(MEM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [31:0]    ram [MEM_WORDS];
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [FAW:0]   count;
  logic           ovf;
  logic [31:0]    gpio, cycle;

  logic           is_mmio;
  logic [5:0]     offset;
  logic [RAW-1:0] ram_idx;
  logic           wr_mmio, push_req, push, pop, full, empty, ready;
  logic [31:0]    status;
  logic           unused_addr;

  assign is_mmio     = (dmem_addr[31:16] == MMIO_BASE);
  assign offset      = dmem_addr[7:2];
  assign ram_idx     = dmem_addr[RAW+1:2];
  assign unused_addr = ^dmem_addr[15:0];

  assign wr_mmio  = dmem_write && is_mmio;
  assign push_req = wr_mmio && (offset == OFF_TXDATA);
  assign full     = (count == (FAW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Full is judged before the edge, so a push racing a pop from a full FIFO is lost.
  assign push     = push_req && !full;
  assign pop      = ready && !empty;

  always_ff @(posedge clock) begin
    if (dmem_write && !is_mmio) ram[ram_idx] <= dmem_write_data;
    if (push) fifo_mem[wr_ptr] <= dmem_write_data[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      gpio   <= '0;
      cycle  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) ovf <= 1'b1;
      else if (wr_mmio && offset == OFF_STATUS) ovf <= 1'b0;
      if (wr_mmio && offset == OFF_GPIO) gpio <= dmem_write_data;
      if (wr_mmio && offset == OFF_CYCLE) cycle <= dmem_write_data;
      else cycle <= cycle + 32'd1;
    end
  end

  dmem_mmio_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clock(clock),
    .reset(reset),
    .data (fifo_mem[rd_ptr]),
    .valid(!empty),
    .ready(ready),
    .tx   (tx),
    .busy (tx_busy)
  );

  always_comb begin
    status                   = '0;
    status[STAT_BUSY]        = tx_busy;
    status[STAT_EMPTY]       = empty;
    status[STAT_FULL]        = full;
    status[STAT_OVF]         = ovf;
    status[STAT_COUNT +: 5]  = 5'(count);
  end

  // Combinational read path: the core samples load data in the same cycle.
  always_comb begin
    dmem_read_data = '0;
    if (dmem_read) begin
      if (is_mmio) begin
        unique case (offset)
          OFF_STATUS: dmem_read_data = status;
          OFF_GPIO:   dmem_read_data = gpio;
          OFF_CYCLE:  dmem_read_data = cycle;
          default:    dmem_read_data = '0;
        endcase
      end else begin
        dmem_read_data = ram[ram_idx];
      end
    end
  end

  assign gpio_out = gpio;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed-plus-random bench for dmem_mmio: RAM/MMIO model, FIFO occupancy model
// and an independent 8N1 receiver that decodes the serial line.
module tb_dmem_mmio;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int MEMW  = 256;
  localparam int FRAME = 10 * CPB;

  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_0008;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_000C;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_0010;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_write_data = '0;
  logic [31:0] dmem_read_data;
  logic        tx;
  logic        tx_busy;
  logic [31:0] gpio_out;

  dmem_mmio #(
    .MEM_WORDS   (MEMW),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_addr      (dmem_addr),
    .dmem_write_data(dmem_write_data),
    .dmem_read_data (dmem_read_data),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .gpio_out       (gpio_out)
  );

  always #5 clock = ~clock;

  int unsigned cc = 0;
  always @(posedge clock) cc <= cc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int unsigned rx_start[$];
  bit          rx_en = 1'b0;
  logic [7:0]  rx_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] stat(input int cnt, input bit ov, input bit busy);
    return {23'b0, 5'(cnt), ov, (cnt == DEPTH), (cnt == 0), busy};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_write = 1'b1;
    dmem_addr = a;
    dmem_write_data = d;
    cyc();
    dmem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_read = 1'b1;
    dmem_addr = a;
    #2;
    d = dmem_read_data;
    dmem_read = 1'b0;
    cyc();
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      cyc();
      k++;
    end
    check("rx_frame_count", rx_q.size(), n);
  endtask

  task automatic compare_rx();
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
  endtask

  // Independent 8N1 receiver: detects start edge, samples mid-bit.
  initial begin
    forever begin
      @(negedge tx);
      if (rx_en && !reset) begin
        repeat (CPB / 2) @(posedge clock);
        #2;
        rx_start.push_back(cc);
        check("rx_start_bit", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clock);
          #2;
          rx_b[i] = tx;
        end
        repeat (CPB) @(posedge clock);
        #2;
        check("rx_stop_bit", {31'b0, tx}, 32'd1);
        rx_q.push_back(rx_b);
      end
    end
  end

  initial begin
    logic [31:0] d, v, a, a2;
    logic [31:0] ref_ram [MEMW];
    logic [31:0] waddr [16];
    int unsigned pop_cycle;
    int cnt, n;
    bit ov, stayed;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    reset = 1'b0;
    rd(A_CYCLE, d);
    check("rst_cycle", d, 32'd0);
    rd(A_STATUS, d);
    check("rst_status", d, stat(0, 0, 0));

    // RAM store/load and aliasing
    wr(32'h0000_0040, 32'h1234_5678);
    rd(32'h0000_0040, d);
    check("ram_lw40", d, 32'h1234_5678);
    rd(32'h0000_0440, d);
    check("ram_alias440", d, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      v = $urandom;
      waddr[i] = a;
      ref_ram[(a >> 2) % MEMW] = v;
      wr(a, v);
    end
    for (int i = 0; i < 16; i++) begin
      a2 = (waddr[i] ^ (32'h0000_1000 * $urandom_range(0, 7))) ^ 32'd3;
      rd(a2, d);
      check($sformatf("ram_rand%0d", i), d, ref_ram[(waddr[i] >> 2) % MEMW]);
    end

    // Same-cycle read/write returns old data; read strobe low returns 0
    wr(32'h0000_0080, 32'hCAFE_0001);
    dmem_read = 1'b1;
    dmem_write = 1'b1;
    dmem_addr = 32'h0000_0080;
    dmem_write_data = 32'hBEEF_0002;
    #2;
    check("rw_same_old", dmem_read_data, 32'hCAFE_0001);
    cyc();
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    #1;
    check("read_idle_zero", dmem_read_data, 32'd0);
    rd(32'h0000_0080, d);
    check("rw_same_new", d, 32'hBEEF_0002);
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_UNMAP, d);
    check("unmapped_0x10", d, 32'd0);
    rd(A_TXDATA, d);
    check("txdata_read", d, 32'd0);

    // CYCLE load and wrap, GPIO
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd(A_CYCLE, d);
    check("cycle_load", d, 32'hFFFF_FFFE);
    rd(A_CYCLE, d);
    check("cycle_max", d, 32'hFFFF_FFFF);
    rd(A_CYCLE, d);
    check("cycle_wrap", d, 32'd0);
    v = $urandom;
    wr(A_CYCLE, v);
    rd(A_CYCLE, d);
    check("cycle_rand_load", d, v);
    rd(A_CYCLE, d);
    check("cycle_rand_inc", d, v + 32'd1);
    wr(A_GPIO, 32'hA5A5_A5A5);
    check("gpio_out", gpio_out, 32'hA5A5_A5A5);
    v = $urandom;
    wr(A_GPIO, v);
    rd(A_GPIO, d);
    check("gpio_read", d, v);
    check("gpio_out_rand", gpio_out, v);

    // Single frame 0x55: busy two cycles after the write, bits at mid-bit
    rx_en = 1'b1;
    wr(A_TXDATA, 32'h0000_0055);
    exp_q.push_back(8'h55);
    check("busy_lag1", {31'b0, tx_busy}, 32'd0);
    cyc();
    check("busy_lag2", {31'b0, tx_busy}, 32'd1);
    repeat (CPB / 2) cyc();
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 32'd0;
      else if (k == 9) v = 32'd1;
      else             v = (32'h55 >> (k - 1)) & 32'd1;
      check($sformatf("frame55_bit%0d", k), {31'b0, tx}, v);
      if (k < 9) repeat (CPB) cyc();
    end
    repeat (CPB / 2) cyc();
    check("frame55_end_busy", {31'b0, tx_busy}, 32'd0);
    check("frame55_end_tx", {31'b0, tx}, 32'd1);

    // Overflow with serializer stalled on the first byte
    b = 8'($urandom);
    wr(A_TXDATA, {24'b0, b});
    exp_q.push_back(b);
    pop_cycle = cc;
    cnt = 0;
    ov = 1'b0;
    n = 9 + $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (cnt < DEPTH) begin
        cnt++;
        exp_q.push_back(b);
      end else begin
        ov = 1'b1;
      end
      wr(A_TXDATA, {24'b0, b});
    end
    rd(A_STATUS, d);
    check("ovf_status", d, stat(cnt, ov, 1));
    wr(A_STATUS, $urandom);
    rd(A_STATUS, d);
    check("ovf_cleared", d, stat(cnt, 0, 1));
    // Push in the very cycle the full FIFO pops: dropped
    while (cc < pop_cycle + FRAME + 1) cyc();
    wr(A_TXDATA, 32'h0000_00EE);
    rd(A_STATUS, d);
    check("push_pop_full", d, stat(DEPTH - 1, 1, 1));
    wait_rx(exp_q.size(), 12 * (FRAME + 1) + 200);
    compare_rx();
    for (int i = 2; i < rx_start.size(); i++)
      check($sformatf("frame_gap%0d", i), rx_start[i] - rx_start[i-1], FRAME + 1);
    rx_q.delete();
    exp_q.delete();
    rx_start.delete();

    // Reset mid-frame with bytes queued
    rx_en = 1'b0;
    wr(A_GPIO, $urandom | 32'd1);
    wr(A_TXDATA, 32'h0000_00C3);
    pop_cycle = cc;
    for (int i = 0; i < 3; i++) wr(A_TXDATA, $urandom);
    wr(A_STATUS, 32'd0);
    while (cc < pop_cycle + 1 + 4 * CPB + CPB / 2) cyc();
    check("pre_reset_busy", {31'b0, tx_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'd1);
    check("async_rst_busy", {31'b0, tx_busy}, 32'd0);
    check("async_rst_gpio", gpio_out, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    rd(A_CYCLE, d);
    check("rst2_cycle", d, 32'd0);
    rd(A_STATUS, d);
    check("rst2_status", d, stat(0, 0, 0));
    rd(A_GPIO, d);
    check("rst2_gpio", d, 32'd0);
    stayed = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) stayed = 1'b0;
      cyc();
    end
    check("flushed_idle", {31'b0, stayed}, 32'd1);

    // Random back-to-back frames after reset
    rx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(A_TXDATA, {24'b0, b});
    end
    wait_rx(exp_q.size(), 4 * (FRAME + 1) + 100);
    compare_rx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
